// File: rtl/seg7_pkg.sv
// Shared constants for active-low 7-segment display blocks.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   // Active-low anode pattern selecting one digit; idx 0 is the rightmost digit.
   function automatic logic [3:0] an_select(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment decoder. Non-decimal codes show a dash
// so corrupted digits are visible rather than silently blank.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup from digit value to segment pattern.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit scanner for a common-anode display.
// Page 0 shows HH.MM, page 1 shows MM.SS. Digits are snapshotted once per
// frame so a frame never mixes old and new time values; the dot after the
// second digit from the left blinks at a frame-counted rate.
module seven_seg_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 100_000,
   parameter int BLINK_FRAMES = 125
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] h2,
   input  logic [3:0] h1,
   input  logic [3:0] m2,
   input  logic [3:0] m1,
   input  logic [3:0] s2,
   input  logic [3:0] s1,
   input  logic       page,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int DIV_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
   localparam logic [BLK_W-1:0] BLK_ZERO = BLK_W'(0);

   // Scan state
   logic [DIV_W-1:0] div_r;
   logic [1:0]       idx_r;
   logic             started_r;
   logic [15:0]      snap_r;
   logic             blink_r;
   logic [BLK_W-1:0] blink_cnt_r;
   logic             frame_start_r;

   // Output registers
   logic [3:0]       an_r;
   logic [6:0]       seg_r;
   logic             dp_r;

   // Combinational helpers
   logic             tick_s;
   logic             frame_tick_s;
   logic [15:0]      page_digits_s;
   logic [3:0]       cur_digit_s;
   logic [6:0]       dec_seg_s;
   logic             lz_blank_s;
   logic [3:0]       an_nxt_s;
   logic [6:0]       seg_nxt_s;
   logic             dp_nxt_s;

   assign tick_s       = (div_r == DIV_LAST);
   assign frame_tick_s = tick_s && (idx_r == 2'd3);

   // Page selection of the four digits to snapshot, leftmost in the top nibble.
   always_comb begin
      page_digits_s = {h2, h1, m2, m1};
      if (page) begin
         page_digits_s = {m2, m1, s2, s1};
      end else begin
         page_digits_s = {h2, h1, m2, m1};
      end
   end

   // Pick the snapshotted digit for the current slot.
   always_comb begin
      cur_digit_s = snap_r[3:0];
      case (idx_r)
         2'd0:    cur_digit_s = snap_r[3:0];
         2'd1:    cur_digit_s = snap_r[7:4];
         2'd2:    cur_digit_s = snap_r[11:8];
         2'd3:    cur_digit_s = snap_r[15:12];
         default: cur_digit_s = snap_r[3:0];
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (cur_digit_s),
      .seg (dec_seg_s)
   );

   // Leading-zero blanking uses the live blank_lz so it reacts within a frame.
   assign lz_blank_s = (idx_r == 2'd3) && blank_lz && (cur_digit_s == 4'd0);

   // Next display values; held dark until the first slot tick after reset.
   always_comb begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
      if (started_r) begin
         if (lz_blank_s) begin
            an_nxt_s  = AN_OFF;
            seg_nxt_s = SEG_BLANK;
         end else begin
            an_nxt_s  = an_select(idx_r);
            seg_nxt_s = dec_seg_s;
         end
         dp_nxt_s = ~((idx_r == 2'd2) && blink_r);
      end else begin
         an_nxt_s  = AN_OFF;
         seg_nxt_s = SEG_BLANK;
         dp_nxt_s  = 1'b1;
      end
   end

   // Slot-rate divider: free-running modulo REFRESH_DIV counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= DIV_ZERO;
      end else if (tick_s) begin
         div_r <= DIV_ZERO;
      end else begin
         div_r <= div_r + DIV_ONE;
      end
   end

   // Slot index advance; started latches on the first slot tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r     <= 2'd3;
         started_r <= 1'b0;
      end else if (tick_s) begin
         idx_r     <= idx_r + 2'd1;
         started_r <= 1'b1;
      end else begin
         idx_r     <= idx_r;
         started_r <= started_r;
      end
   end

   // Frame boundary: snapshot digits, pulse frame_start, advance blink timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_r        <= 16'h0000;
         frame_start_r <= 1'b0;
         blink_cnt_r   <= BLK_ZERO;
         blink_r       <= 1'b0;
      end else if (frame_tick_s) begin
         snap_r        <= page_digits_s;
         frame_start_r <= 1'b1;
         if (blink_cnt_r == BLK_LAST) begin
            blink_cnt_r <= BLK_ZERO;
            blink_r     <= ~blink_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + BLK_ONE;
         end
      end else begin
         frame_start_r <= 1'b0;
      end
   end

   // Registered display drive, one cycle behind the scan state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r  <= AN_OFF;
         seg_r <= SEG_BLANK;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an_nxt_s;
         seg_r <= seg_nxt_s;
         dp_r  <= dp_nxt_s;
      end
   end

   assign an          = an_r;
   assign seg         = seg_r;
   assign dp          = dp_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with REFRESH_DIV=4, BLINK_FRAMES=2.
// The stimulus process pushes the hand-derived expected outputs for each
// upcoming cycle; the monitor pops one entry per sample and compares.
module tb_seven_seg_scanner;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] h2, h1, m2, m1, s2, s1;
   logic       page, blank_lz;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp, frame_start;

   typedef struct packed {
      logic       fs;
      logic       dp;
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   sample = 0;

   localparam logic [6:0] D1   = 7'b1111001;
   localparam logic [6:0] D2   = 7'b0100100;
   localparam logic [6:0] D3   = 7'b0110000;
   localparam logic [6:0] D4   = 7'b0011001;
   localparam logic [6:0] D5   = 7'b0010010;
   localparam logic [6:0] D6   = 7'b0000010;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] BLK  = 7'h7F;

   seven_seg_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .h2          (h2),
      .h1          (h1),
      .m2          (m2),
      .m1          (m1),
      .s2          (s2),
      .s1          (s1),
      .page        (page),
      .blank_lz    (blank_lz),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Monitor: samples 1 ns after each falling clock edge or reset assertion.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({frame_start, dp, an, seg} !== e) begin
               errors++;
               $display("FAIL out sample=%0d t=%0t got fs=%b dp=%b an=%b seg=%b, want fs=%b dp=%b an=%b seg=%b",
                        sample, $time, frame_start, dp, an, seg, e.fs, e.dp, e.an, e.seg);
            end
            sample++;
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
      exp_t e;
      e.fs  = f;
      e.dp  = d;
      e.an  = a;
      e.seg = s;
      exp_q.push_back(e);
   endtask

   // Queue the expectation for the next cycle, then advance one cycle.
   task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
      push_exp(a, s, d, f);
      @(negedge clk);
      #2;
   endtask

   task automatic slot(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f_last);
      for (int i = 0; i < 4; i++) begin
         step(a, s, d, (i == 3) ? f_last : 1'b0);
      end
   endtask

   // Four dark cycles after reset release; frame_start on the fourth.
   task automatic startup();
      for (int i = 0; i < 4; i++) begin
         step(4'b1111, BLK, 1'b1, (i == 3) ? 1'b1 : 1'b0);
      end
   endtask

   task automatic frame_head(input logic [6:0] s0);
      slot(4'b1110, s0, 1'b1, 1'b0);
   endtask

   task automatic frame_tail(input logic [6:0] s1d, input logic [6:0] s2d, input logic dp2,
                             input logic [6:0] s3d, input logic blank3);
      slot(4'b1101, s1d, 1'b1, 1'b0);
      slot(4'b1011, s2d, dp2, 1'b0);
      if (blank3) begin
         slot(4'b1111, BLK, 1'b1, 1'b1);
      end else begin
         slot(4'b0111, s3d, 1'b1, 1'b1);
      end
   endtask

   initial begin : stimulus
      h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd5; s1 = 4'd6;
      page = 1'b0; blank_lz = 1'b0;
      @(negedge clk);
      #2;
      // Reset state
      step(4'b1111, BLK, 1'b1, 1'b0);
      step(4'b1111, BLK, 1'b1, 1'b0);
      rst_n = 1'b1;

      // Tests 1/2: startup and free run on HH.MM = 12.34
      startup();
      frame_head(D4); frame_tail(D3, D2, 1'b1, D1, 1'b0);   // frame 1, blink off
      frame_head(D4); frame_tail(D3, D2, 1'b0, D1, 1'b0);   // frame 2, blink on

      // Test 3: page switch mid-frame takes effect on the next frame
      frame_head(D4);
      page = 1'b1;
      frame_tail(D3, D2, 1'b0, D1, 1'b0);                   // frame 3, blink on
      frame_head(D6);
      h2 = 4'd0; page = 1'b0; blank_lz = 1'b1;
      frame_tail(D5, D4, 1'b1, D3, 1'b0);                   // frame 4 shows 34.56

      // Test 4: leading-zero blanking, then a nonzero leading digit
      frame_head(D4);
      h2 = 4'd1;
      frame_tail(D3, D2, 1'b1, D1, 1'b1);                   // frame 5, idx3 blanked
      frame_head(D4);
      m1 = 4'hA;
      frame_tail(D3, D2, 1'b0, D1, 1'b0);                   // frame 6, blink on

      // Test 5: non-decimal digit shows a dash
      frame_head(DASH); frame_tail(D3, D2, 1'b0, D1, 1'b0); // frame 7, blink on
      frame_head(DASH);                                     // frame 8, blink off
      step(4'b1101, D3, 1'b1, 1'b0);
      step(4'b1101, D3, 1'b1, 1'b0);

      // Test 6: asynchronous reset mid-slot, checked before any clock edge
      push_exp(4'b1111, BLK, 1'b1, 1'b0);
      rst_n = 1'b0;
      step(4'b1111, BLK, 1'b1, 1'b0);
      m1 = 4'd4; blank_lz = 1'b0;
      step(4'b1111, BLK, 1'b1, 1'b0);
      rst_n = 1'b1;
      startup();
      frame_head(D4); frame_tail(D3, D2, 1'b1, D1, 1'b0);

      // Every expectation must have been consumed by the monitor.
      @(negedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
